prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/loader_pkg.sv | 22 ++
 rtl/sat_counter.sv | 46 ++++
 rtl/prog_loader.sv | 162 ++++++++++++++++
 tb/tb_prog_loader.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// -----------------------------------------------------------------------------
// loader_pkg
//   Shared types and defaults for the program loader block.
//   - state_e : loader sequencing states (IDLE / LOAD / RUN / DONE)
//   - D_DEF   : default program-counter / instruction-address width
//   - IW_DEF  : default machine-code word width
//   - CW_DEF  : default run-cycle counter width
// -----------------------------------------------------------------------------
package loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int D_DEF  = 12;
  localparam int IW_DEF = 9;
  localparam int CW_DEF = 16;

endpackage

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
//   Up-counter that sticks at its all-ones value instead of wrapping.
//   Ports:
//     clk   : rising-edge clock
//     rst_n : asynchronous active-low reset, clears the count
//     clr   : synchronous clear (wins over en)
//     en    : count one step this cycle
//     cnt   : current count value
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] CNT_MAX = {W{1'b1}};
  localparam logic [W-1:0] CNT_ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/prog_loader.sv
// -----------------------------------------------------------------------------
// prog_loader
//   Streams a host program into instruction memory, then releases the CPU
//   core and waits for it to finish, handshaking with the host via req/ack.
//
//   Optional feature macro: PROG_LOADER_CYCLE_CNT_EN
//     defined   -> cycle_cnt counts RUN cycles (saturating sat_counter)
//     undefined -> counter logic absent, cycle_cnt tied to 0
//
//   Ports:
//     clk        : rising-edge clock
//     reset      : asynchronous active-low reset
//     req        : host run request (level, four-phase with ack)
//     in_valid   : host instruction word valid
//     in_data    : host instruction word
//     in_last    : final program word marker (qualified by in_valid)
//     in_ready   : loader accepts a word this cycle
//     wr_en      : instruction-memory write strobe
//     wr_addr    : instruction-memory write address
//     wr_data    : instruction-memory write data
//     core_reset : holds the CPU core in reset while high
//     done_in    : CPU reached its terminal address
//     ack        : run complete, to host
//     cycle_cnt  : clock cycles spent running
//     load_err   : program overflowed instruction memory
// -----------------------------------------------------------------------------
module prog_loader
  import loader_pkg::*;
#(
  parameter int D  = D_DEF,
  parameter int IW = IW_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic          in_valid,
  input  logic [IW-1:0] in_data,
  input  logic          in_last,
  output logic          in_ready,
  output logic          wr_en,
  output logic [D-1:0]  wr_addr,
  output logic [IW-1:0] wr_data,
  output logic          core_reset,
  input  logic          done_in,
  output logic          ack,
  output logic [CW-1:0] cycle_cnt,
  output logic          load_err
);

  localparam logic [D-1:0] ADDR_TOP = {D{1'b1}};
  localparam logic [D-1:0] ADDR_ONE = {{(D-1){1'b0}}, 1'b1};

  state_e       state_q, state_d;
  logic [D-1:0] addr_q, addr_d;
  logic         load_err_q, load_err_d;
  logic         at_top;
  logic         cnt_clr;
  logic         cnt_en;

  assign at_top = (addr_q == ADDR_TOP);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    load_err_d = load_err_q;
    cnt_clr    = 1'b0;
    cnt_en     = 1'b0;
    in_ready   = 1'b0;
    core_reset = 1'b1;
    ack        = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
          state_d    = ST_LOAD;
          addr_d     = '0;
          load_err_d = 1'b0;
          cnt_clr    = 1'b1;
        end
      end

      ST_LOAD: begin
        // A falling req withdraws readiness so an abort cycle never
        // writes memory or moves the address counter.
        in_ready = req;
        if (!req) begin
          state_d = ST_IDLE;
        end else if (in_valid) begin
          if (in_last) begin
            state_d = ST_RUN;
          end else if (at_top) begin
            state_d    = ST_IDLE;
            load_err_d = 1'b1;
          end
          // The counter parks at the top address rather than wrapping.
          if (!at_top) begin
            addr_d = addr_q + ADDR_ONE;
          end
        end
      end

      ST_RUN: begin
        core_reset = 1'b0;
        // Abort outranks done_in; neither the abort nor the done cycle counts.
        if (!req) begin
          state_d = ST_IDLE;
        end else if (done_in) begin
          state_d = ST_DONE;
        end else begin
          cnt_en = 1'b1;
        end
      end

      ST_DONE: begin
        ack = 1'b1;
        if (!req) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      load_err_q <= load_err_d;
    end
  end

  // Memory write port is a zero-latency view of the accepted host word.
  assign wr_en    = in_ready & in_valid;
  assign wr_addr  = addr_q;
  assign wr_data  = in_data;
  assign load_err = load_err_q;

`ifdef PROG_LOADER_CYCLE_CNT_EN
  sat_counter #(
    .W (CW)
  ) u_cycle_cnt (
    .clk   (clk),
    .rst_n (reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .cnt   (cycle_cnt)
  );
`else
  logic unused_cnt_ctrl;
  assign unused_cnt_ctrl = cnt_clr ^ cnt_en;
  assign cycle_cnt       = '0;
`endif

endmodule

// File: tb/tb_prog_loader.sv
`timescale 1ns/1ps
module tb_prog_loader;

  localparam int IW = 9;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          req = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic          done_in = 1'b0;
  logic [IW-1:0] in_data = '0;

  // DUT A: default geometry
  logic        a_in_ready, a_wr_en, a_core_reset, a_ack, a_load_err;
  logic [11:0] a_wr_addr;
  logic [8:0]  a_wr_data;
  logic [15:0] a_cycle_cnt;
  // DUT B: 8-word instruction memory
  logic        b_in_ready, b_wr_en, b_core_reset, b_ack, b_load_err;
  logic [2:0]  b_wr_addr;
  logic [8:0]  b_wr_data;
  logic [15:0] b_cycle_cnt;
  // DUT C: 4-bit cycle counter
  logic        unused_c_rdy, unused_c_wen, unused_c_crst, unused_c_ack, unused_c_err;
  logic [11:0] unused_c_addr;
  logic [8:0]  unused_c_data;
  logic [3:0]  c_cycle_cnt;

  prog_loader #(.D(12), .IW(9), .CW(16)) u_a (
    .clk(clk), .reset(rst_n), .req(req), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(a_in_ready), .wr_en(a_wr_en), .wr_addr(a_wr_addr),
    .wr_data(a_wr_data), .core_reset(a_core_reset), .done_in(done_in), .ack(a_ack),
    .cycle_cnt(a_cycle_cnt), .load_err(a_load_err));

  prog_loader #(.D(3), .IW(9), .CW(16)) u_b (
    .clk(clk), .reset(rst_n), .req(req), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(b_in_ready), .wr_en(b_wr_en), .wr_addr(b_wr_addr),
    .wr_data(b_wr_data), .core_reset(b_core_reset), .done_in(done_in), .ack(b_ack),
    .cycle_cnt(b_cycle_cnt), .load_err(b_load_err));

  prog_loader #(.D(12), .IW(9), .CW(4)) u_c (
    .clk(clk), .reset(rst_n), .req(req), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(unused_c_rdy), .wr_en(unused_c_wen), .wr_addr(unused_c_addr),
    .wr_data(unused_c_data), .core_reset(unused_c_crst), .done_in(done_in), .ack(unused_c_ack),
    .cycle_cnt(c_cycle_cnt), .load_err(unused_c_err));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int addr;
    int data;
  } wr_t;

  wr_t           a_log[$];
  wr_t           b_log[$];
  logic [IW-1:0] prog[$];
  int            gaps[$];

  // Record every memory write strobe, sampled mid-cycle.
  always @(negedge clk) begin
    if (a_wr_en) a_log.push_back('{int'(a_wr_addr), int'(a_wr_data)});
    if (b_wr_en) b_log.push_back('{int'(b_wr_addr), int'(b_wr_data)});
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected run-cycle count: number of counted RUN cycles, saturated to the
  // counter width; always zero when the counter feature is compiled out.
  function automatic int exp_cnt(input int n, input int cw);
    int mx;
    mx = (1 << cw) - 1;
`ifdef PROG_LOADER_CYCLE_CNT_EN
    return (n > mx) ? mx : n;
`else
    return 0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic make_prog(input int n, input int maxgap);
    prog.delete();
    gaps.delete();
    for (int i = 0; i < n; i++) begin
      prog.push_back(IW'($urandom_range(0, (1 << IW) - 1)));
      gaps.push_back(int'($urandom_range(0, maxgap)));
    end
  endtask

  task automatic feed_program(input bit with_last);
    for (int i = 0; i < prog.size(); i++) begin
      in_valid = 1'b0;
      in_last  = 1'b0;
      repeat (gaps[i]) tick();
      in_valid = 1'b1;
      in_data  = prog[i];
      in_last  = with_last && (i == prog.size() - 1);
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic test_reset();
    in_valid = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    checks++; if (a_wr_en !== 1'b0) begin failures++; $display("FAIL rst_wr_en: got %b want 0", a_wr_en); end
    checks++; if (a_in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready: got %b want 0", a_in_ready); end
    tick(); tick();
    checks++; if (a_core_reset !== 1'b1) begin failures++; $display("FAIL rst_core_reset: got %b want 1", a_core_reset); end
    checks++; if (a_ack !== 1'b0) begin failures++; $display("FAIL rst_ack: got %b want 0", a_ack); end
    checks++; if (a_cycle_cnt !== 16'd0) begin failures++; $display("FAIL rst_cycle_cnt: got %0d want 0", a_cycle_cnt); end
    checks++; if (a_load_err !== 1'b0) begin failures++; $display("FAIL rst_load_err: got %b want 0", a_load_err); end
    checks++; if (a_wr_addr !== 12'd0) begin failures++; $display("FAIL rst_wr_addr: got %0d want 0", a_wr_addr); end
    in_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    checks++; if (a_in_ready !== 1'b0 || a_core_reset !== 1'b1) begin failures++; $display("FAIL rst_idle: got rdy=%b crst=%b want 0/1", a_in_ready, a_core_reset); end
    checks++; if (a_log.size() != 0) begin failures++; $display("FAIL rst_no_writes: got %0d writes want 0", a_log.size()); end
  endtask

  task automatic test_load_fixed();
    a_log.delete();
    prog.delete(); gaps.delete();
    prog.push_back(9'h1A0); prog.push_back(9'h0F3); prog.push_back(9'h100); prog.push_back(9'h1FF);
    for (int i = 0; i < 4; i++) gaps.push_back(0);
    req = 1'b1;
    tick();
    checks++; if (a_in_ready !== 1'b1) begin failures++; $display("FAIL fixed_ready: got %b want 1", a_in_ready); end
    feed_program(1'b1);
    checks++; if (a_core_reset !== 1'b0 || a_in_ready !== 1'b0) begin failures++; $display("FAIL fixed_run_entry: got crst=%b rdy=%b want 0/0", a_core_reset, a_in_ready); end
    checks++; if (a_log.size() != 4) begin failures++; $display("FAIL fixed_count: got %0d want 4", a_log.size()); end
    for (int i = 0; i < a_log.size() && i < 4; i++) begin
      checks++;
      if (a_log[i].addr !== i || a_log[i].data !== int'(prog[i])) begin
        failures++; $display("FAIL fixed_write%0d: got addr=%0d data=%0h want addr=%0d data=%0h", i, a_log[i].addr, a_log[i].data, i, prog[i]);
      end
    end
    req = 1'b0;
    tick();
    checks++; if (a_core_reset !== 1'b1 || a_ack !== 1'b0) begin failures++; $display("FAIL fixed_abort: got crst=%b ack=%b want 1/0", a_core_reset, a_ack); end
  endtask

  task automatic test_stall();
    for (int it = 0; it < 3; it++) begin
      a_log.delete();
      make_prog(int'($urandom_range(4, 10)), 2);
      gaps[1] = 3;
      req = 1'b1;
      tick();
      feed_program(1'b1);
      checks++; if (a_core_reset !== 1'b0) begin failures++; $display("FAIL stall_run_entry%0d: got crst=%b want 0", it, a_core_reset); end
      checks++; if (a_log.size() != prog.size()) begin failures++; $display("FAIL stall_count%0d: got %0d want %0d", it, a_log.size(), prog.size()); end
      for (int i = 0; i < a_log.size() && i < prog.size(); i++) begin
        checks++;
        if (a_log[i].addr !== i || a_log[i].data !== int'(prog[i])) begin
          failures++; $display("FAIL stall_write%0d_%0d: got addr=%0d data=%0h want addr=%0d data=%0h", it, i, a_log[i].addr, a_log[i].data, i, prog[i]);
        end
      end
      req = 1'b0;
      tick();
    end
  endtask

  task automatic test_run(input int n);
    a_log.delete();
    make_prog(int'($urandom_range(1, 3)), 1);
    req = 1'b1;
    tick();
    feed_program(1'b1);
    done_in = 1'b0;
    repeat (n) tick();
    checks++; if (a_core_reset !== 1'b0 || a_ack !== 1'b0) begin failures++; $display("FAIL run%0d_running: got crst=%b ack=%b want 0/0", n, a_core_reset, a_ack); end
    done_in = 1'b1;
    tick();
    checks++; if (a_ack !== 1'b1 || a_core_reset !== 1'b1) begin failures++; $display("FAIL run%0d_done: got ack=%b crst=%b want 1/1", n, a_ack, a_core_reset); end
    checks++; if (a_cycle_cnt !== 16'(exp_cnt(n, 16))) begin failures++; $display("FAIL run%0d_cnt: got %0d want %0d", n, a_cycle_cnt, exp_cnt(n, 16)); end
    checks++; if (c_cycle_cnt !== 4'(exp_cnt(n, 4))) begin failures++; $display("FAIL run%0d_cnt_sat: got %0d want %0d", n, c_cycle_cnt, exp_cnt(n, 4)); end
    tick();
    checks++; if (a_cycle_cnt !== 16'(exp_cnt(n, 16)) || a_ack !== 1'b1) begin failures++; $display("FAIL run%0d_hold: got cnt=%0d ack=%b want %0d/1", n, a_cycle_cnt, a_ack, exp_cnt(n, 16)); end
    done_in = 1'b0;
    req = 1'b0;
    tick();
    checks++; if (a_ack !== 1'b0 || a_core_reset !== 1'b1 || a_in_ready !== 1'b0) begin failures++; $display("FAIL run%0d_idle: got ack=%b crst=%b rdy=%b want 0/1/0", n, a_ack, a_core_reset, a_in_ready); end
    checks++; if (a_cycle_cnt !== 16'(exp_cnt(n, 16))) begin failures++; $display("FAIL run%0d_idle_cnt: got %0d want %0d", n, a_cycle_cnt, exp_cnt(n, 16)); end
    checks++; if (a_log.size() != prog.size()) begin failures++; $display("FAIL run%0d_writes: got %0d want %0d", n, a_log.size(), prog.size()); end
  endtask

  task automatic test_abort_run();
    make_prog(2, 0);
    req = 1'b1;
    tick();
    feed_program(1'b1);
    repeat (5) tick();
    req = 1'b0;
    done_in = 1'b1;
    tick();
    checks++; if (a_ack !== 1'b0 || a_core_reset !== 1'b1 || a_in_ready !== 1'b0) begin failures++; $display("FAIL abort_run_idle: got ack=%b crst=%b rdy=%b want 0/1/0", a_ack, a_core_reset, a_in_ready); end
    checks++; if (a_cycle_cnt !== 16'(exp_cnt(5, 16))) begin failures++; $display("FAIL abort_run_cnt: got %0d want %0d", a_cycle_cnt, exp_cnt(5, 16)); end
    done_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (a_ack !== 1'b0) begin failures++; $display("FAIL abort_run_ack%0d: got %b want 0", i, a_ack); end
    end
  endtask

  task automatic test_abort_load();
    a_log.delete();
    make_prog(2, 0);
    req = 1'b1;
    tick();
    done_in = 1'b1;
    feed_program(1'b0);
    checks++; if (a_in_ready !== 1'b1 || a_ack !== 1'b0) begin failures++; $display("FAIL abort_load_ignore_done: got rdy=%b ack=%b want 1/0", a_in_ready, a_ack); end
    done_in = 1'b0;
    req = 1'b0;
    in_valid = 1'b1;
    in_data = 9'h055;
    tick();
    tick();
    checks++; if (a_in_ready !== 1'b0 || a_core_reset !== 1'b1) begin failures++; $display("FAIL abort_load_idle: got rdy=%b crst=%b want 0/1", a_in_ready, a_core_reset); end
    checks++; if (a_wr_addr !== 12'd2) begin failures++; $display("FAIL abort_load_addr_hold: got %0d want 2", a_wr_addr); end
    checks++; if (a_log.size() != 2) begin failures++; $display("FAIL abort_load_writes: got %0d want 2", a_log.size()); end
    in_valid = 1'b0;
  endtask

  task automatic test_overflow();
    req = 1'b0;
    tick();
    b_log.delete();
    make_prog(9, 0);
    req = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_last = 1'b0;
      in_data = prog[i];
      tick();
    end
    checks++; if (b_load_err !== 1'b1) begin failures++; $display("FAIL ovf_load_err: got %b want 1", b_load_err); end
    checks++; if (b_in_ready !== 1'b0 || b_core_reset !== 1'b1 || b_ack !== 1'b0) begin failures++; $display("FAIL ovf_idle: got rdy=%b crst=%b ack=%b want 0/1/0", b_in_ready, b_core_reset, b_ack); end
    checks++; if (b_wr_addr !== 3'd7) begin failures++; $display("FAIL ovf_no_wrap: got addr %0d want 7", b_wr_addr); end
    req = 1'b0;
    in_data = prog[8];
    tick();
    in_valid = 1'b0;
    tick();
    checks++; if (b_load_err !== 1'b1) begin failures++; $display("FAIL ovf_err_hold: got %b want 1", b_load_err); end
    checks++; if (b_cycle_cnt !== 16'd0) begin failures++; $display("FAIL ovf_cnt: got %0d want 0", b_cycle_cnt); end
    checks++; if (b_log.size() != 8) begin failures++; $display("FAIL ovf_count: got %0d want 8", b_log.size()); end
    for (int i = 0; i < b_log.size() && i < 8; i++) begin
      checks++;
      if (b_log[i].addr !== i || b_log[i].data !== int'(prog[i])) begin
        failures++; $display("FAIL ovf_write%0d: got addr=%0d data=%0h want addr=%0d data=%0h", i, b_log[i].addr, b_log[i].data, i, prog[i]);
      end
    end
    req = 1'b1;
    tick();
    checks++; if (b_load_err !== 1'b0 || b_wr_addr !== 3'd0 || b_in_ready !== 1'b1) begin failures++; $display("FAIL ovf_restart: got err=%b addr=%0d rdy=%b want 0/0/1", b_load_err, b_wr_addr, b_in_ready); end
    req = 1'b0;
    tick();
  endtask

  task automatic test_reset_midload();
    a_log.delete();
    make_prog(2, 0);
    req = 1'b1;
    tick();
    feed_program(1'b0);
    in_valid = 1'b1;
    in_data = 9'h0AA;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (a_wr_en !== 1'b0 || a_in_ready !== 1'b0) begin failures++; $display("FAIL midrst_strobe: got wen=%b rdy=%b want 0/0", a_wr_en, a_in_ready); end
    checks++; if (a_core_reset !== 1'b1 || a_ack !== 1'b0 || a_load_err !== 1'b0) begin failures++; $display("FAIL midrst_ctrl: got crst=%b ack=%b err=%b want 1/0/0", a_core_reset, a_ack, a_load_err); end
    checks++; if (a_wr_addr !== 12'd0 || a_cycle_cnt !== 16'd0) begin failures++; $display("FAIL midrst_counters: got addr=%0d cnt=%0d want 0/0", a_wr_addr, a_cycle_cnt); end
    tick();
    tick();
    in_valid = 1'b0;
    checks++; if (a_log.size() != 2) begin failures++; $display("FAIL midrst_writes: got %0d want 2", a_log.size()); end
    rst_n = 1'b1;
    tick();
    checks++; if (a_in_ready !== 1'b1 || a_wr_addr !== 12'd0) begin failures++; $display("FAIL midrst_reload: got rdy=%b addr=%0d want 1/0", a_in_ready, a_wr_addr); end
    a_log.delete();
    make_prog(3, 1);
    feed_program(1'b1);
    checks++; if (a_log.size() != 3) begin failures++; $display("FAIL midrst_reload_count: got %0d want 3", a_log.size()); end
    for (int i = 0; i < a_log.size() && i < 3; i++) begin
      checks++;
      if (a_log[i].addr !== i || a_log[i].data !== int'(prog[i])) begin
        failures++; $display("FAIL midrst_write%0d: got addr=%0d data=%0h want addr=%0d data=%0h", i, a_log[i].addr, a_log[i].data, i, prog[i]);
      end
    end
    checks++; if (a_core_reset !== 1'b0 || a_cycle_cnt !== 16'd0) begin failures++; $display("FAIL midrst_run: got crst=%b cnt=%0d want 0/0", a_core_reset, a_cycle_cnt); end
    req = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    for (int it = 0; it < 4; it++) begin
      int n;
      a_log.delete();
      make_prog(int'($urandom_range(1, 12)), 1);
      n = int'($urandom_range(0, 30));
      req = 1'b1;
      tick();
      feed_program(1'b1);
      repeat (n) tick();
      done_in = 1'b1;
      tick();
      done_in = 1'b0;
      checks++; if (a_ack !== 1'b1 || a_cycle_cnt !== 16'(exp_cnt(n, 16))) begin failures++; $display("FAIL b2b%0d_done: got ack=%b cnt=%0d want 1/%0d", it, a_ack, a_cycle_cnt, exp_cnt(n, 16)); end
      checks++; if (a_log.size() != prog.size()) begin failures++; $display("FAIL b2b%0d_count: got %0d want %0d", it, a_log.size(), prog.size()); end
      for (int i = 0; i < a_log.size() && i < prog.size(); i++) begin
        checks++;
        if (a_log[i].addr !== i || a_log[i].data !== int'(prog[i])) begin
          failures++; $display("FAIL b2b%0d_write%0d: got addr=%0d data=%0h want addr=%0d data=%0h", it, i, a_log[i].addr, a_log[i].data, i, prog[i]);
        end
      end
      req = 1'b0;
      tick();
      checks++; if (a_ack !== 1'b0) begin failures++; $display("FAIL b2b%0d_ack_drop: got %b want 0", it, a_ack); end
    end
  endtask

  initial begin
    test_reset();
    test_load_fixed();
    test_stall();
    test_run(20);
    test_run(int'($urandom_range(1, 40)));
    test_abort_run();
    test_abort_load();
    test_overflow();
    test_reset_midload();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
